// File: rtl/mysystem_sysid_pkg.sv
// Shared word map, INFO field layout and defaults for the system-ID / housekeeping slave.
package mysystem_sysid_pkg;

  localparam int ADDR_SYSTEM_ID = 0;
  localparam int ADDR_TIMESTAMP = 1;
  localparam int ADDR_UPTIME_LO = 2;
  localparam int ADDR_UPTIME_HI = 3;
  localparam int ADDR_SCRATCH   = 4;
  localparam int ADDR_INFO      = 5;
  localparam int ADDR_USER_BASE = 6;

  localparam int INFO_VERSION_LSB  = 0;
  localparam int INFO_LATENCY_LSB  = 16;
  localparam int INFO_NUM_USER_LSB = 24;

  localparam logic [15:0] DEFAULT_VERSION = 16'h0002;

  function automatic logic [31:0] info_word(input int num_user, input int read_latency,
                                            input logic [15:0] version);
    logic [31:0] w;
    w = '0;
    w[INFO_NUM_USER_LSB +: 8] = num_user[7:0];
    w[INFO_LATENCY_LSB +: 8]  = read_latency[7:0];
    w[INFO_VERSION_LSB +: 16] = version;
    return w;
  endfunction

endpackage

// File: rtl/mysystem_sysid_rd_pipe.sv
// Valid/data delay line for the read-return path; every stage has its own valid bit.
module mysystem_sysid_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Data only advances alongside a valid bit, so the output holds its last delivered word.
  always_comb begin
    vld_d[0]  = in_vld;
    data_d[0] = in_vld ? in_data : data_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/mysystem_sysid_ext.sv
// Avalon-MM system-ID slave: ID/timestamp, 64-bit uptime with coherent high-word capture,
// byte-writable scratch, INFO word and user constants, returned through a fixed-latency pipe.
module mysystem_sysid_ext
  import mysystem_sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter int          NUM_USER     = 2,
  parameter logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] USER_WORDS = '0,
  parameter int          READ_LATENCY = 1,
  parameter int          ADDR_W       = 6,
  parameter logic [15:0] VERSION      = DEFAULT_VERSION
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (NUM_USER < 0 || NUM_USER > 32) begin : g_bad_num_user
    $error("NUM_USER must be in 0..32");
  end
  if ((64'd1 << ADDR_W) < 64'(ADDR_USER_BASE + NUM_USER)) begin : g_bad_addr_w
    $error("ADDR_W too narrow for the register map");
  end

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata;
  logic        rd_lo, wr_scratch;

  assign rd_lo      = read && (address == ADDR_W'(ADDR_UPTIME_LO));
  // A read in the same cycle wins; the write is dropped.
  assign wr_scratch = write && !read && (address == ADDR_W'(ADDR_SCRATCH));

  always_comb begin
    uptime_d    = uptime_q + 64'd1;
    hi_shadow_d = rd_lo ? uptime_q[63:32] : hi_shadow_q;
    scratch_d   = scratch_q;
    if (wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_W'(ADDR_SYSTEM_ID): rdata = SYSTEM_ID;
      ADDR_W'(ADDR_TIMESTAMP): rdata = TIMESTAMP;
      ADDR_W'(ADDR_UPTIME_LO): rdata = uptime_q[31:0];
      ADDR_W'(ADDR_UPTIME_HI): rdata = hi_shadow_q;
      ADDR_W'(ADDR_SCRATCH):   rdata = scratch_q;
      ADDR_W'(ADDR_INFO):      rdata = info_word(NUM_USER, READ_LATENCY, VERSION);
      default:                 rdata = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++) begin
      if (address == ADDR_W'(ADDR_USER_BASE + k)) rdata = USER_WORDS[32*k +: 32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      uptime_q    <= '0;
      hi_shadow_q <= '0;
      scratch_q   <= '0;
    end else begin
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
      scratch_q   <= scratch_d;
    end
  end

  mysystem_sysid_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (32)
  ) u_rd_pipe (
    .clock    (clock),
    .clear_n  (reset_n),
    .in_vld   (read),
    .in_data  (rdata),
    .out_vld  (readdatavalid),
    .out_data (readdata)
  );

endmodule

// File: tb/tb_mysystem_sysid_ext.sv
// Directed bench for mysystem_sysid_ext: one instance at read latency 2, one at latency 4.
module tb_mysystem_sysid_ext;

  localparam logic [31:0] SYS_ID = 32'h5741_0A30;
  localparam logic [31:0] TSTAMP = 32'd1463110960;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] rdata2, rdata4;
  logic        rdv2, rdv4;

  int errors = 0;
  int checks = 0;
  logic [63:0] mcnt = '0;

  always #5 clock = ~clock;

  // Reference uptime: number of post-reset edges seen so far.
  always @(posedge clock) begin
    if (!reset_n) mcnt <= '0;
    else          mcnt <= mcnt + 64'd1;
  end

  mysystem_sysid_ext #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .NUM_USER(2),
    .USER_WORDS({32'hBBBB_BBBB, 32'hAAAA_AAAA}), .READ_LATENCY(2),
    .ADDR_W(6), .VERSION(16'h0002)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata2), .readdatavalid(rdv2)
  );

  mysystem_sysid_ext #(
    .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .NUM_USER(2),
    .USER_WORDS({32'hBBBB_BBBB, 32'hAAAA_AAAA}), .READ_LATENCY(4),
    .ADDR_W(6), .VERSION(16'h0002)
  ) dut4 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rdata4), .readdatavalid(rdv4)
  );

  typedef struct {
    int          addr;
    logic [31:0] exp;
    bit          live;
  } rd_vec_t;

  rd_vec_t     tbl [6];
  logic [5:0]  baddr [8];
  logic [31:0] bexp [8];
  logic [31:0] got [$];
  int          first_i, last_i;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
    address = addr[5:0]; write = 1'b1; writedata = d; byteenable = be;
    tick();
    write = 1'b0; byteenable = 4'h0;
  endtask

  // Single read; measures cycles from accept edge to the valid pulse.
  task automatic read_one(input bit use4, input int addr, input logic [31:0] exp,
                          input string name, input bit wr_too, input logic [31:0] wd);
    int          lat;
    bit          seen;
    logic [31:0] d;
    lat = 0; seen = 1'b0; d = '0;
    address = addr[5:0]; read = 1'b1;
    write = wr_too; writedata = wd; byteenable = wr_too ? 4'hF : 4'h0;
    tick();
    read = 1'b0; write = 1'b0; byteenable = 4'h0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      if (use4 ? rdv4 : rdv2) begin
        seen = 1'b1; lat = i; d = use4 ? rdata4 : rdata2;
      end else begin
        tick();
      end
    end
    check({name, "_vld"}, 64'(seen), 64'd1);
    check({name, "_lat"}, 64'(lat), use4 ? 64'd4 : 64'd2);
    check({name, "_data"}, 64'(d), 64'(exp));
  endtask

  // Back-to-back reads on the latency-2 instance, collecting every valid pulse.
  task automatic burst(input int n);
    got.delete(); first_i = -1; last_i = -1;
    for (int i = 0; i < n + 6; i++) begin
      if (i < n) begin read = 1'b1; address = baddr[i]; end
      else read = 1'b0;
      tick();
      if (rdv2) begin
        got.push_back(rdata2);
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
  endtask

  initial begin
    int npulse;

    tbl[0] = '{addr: 0, exp: SYS_ID,         live: 1'b0};
    tbl[1] = '{addr: 1, exp: TSTAMP,         live: 1'b0};
    tbl[2] = '{addr: 2, exp: 32'h0,          live: 1'b1};
    tbl[3] = '{addr: 3, exp: 32'h0,          live: 1'b0};
    tbl[4] = '{addr: 4, exp: 32'h0,          live: 1'b0};
    tbl[5] = '{addr: 5, exp: 32'h0202_0002,  live: 1'b0};

    // Reset state
    reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst_rdv2", 64'(rdv2), 64'd0);
    check("rst_rdata2", 64'(rdata2), 64'd0);
    check("rst_rdv4", 64'(rdv4), 64'd0);
    check("rst_rdata4", 64'(rdata4), 64'd0);
    reset_n = 1'b1;

    // Register map walk
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].live) tbl[i].exp = mcnt[31:0];
      read_one(1'b0, tbl[i].addr, tbl[i].exp, $sformatf("map_a%0d", tbl[i].addr), 1'b0, '0);
    end

    // Scratch byte lanes and ignored writes
    wr(4, 32'hDEAD_BEEF, 4'b1111);
    wr(4, 32'h0000_1200, 4'b0010);
    read_one(1'b0, 4, 32'hDEAD_12EF, "scratch_be", 1'b0, '0);
    wr(0, 32'h1111_1111, 4'hF);
    wr(1, 32'h2222_2222, 4'hF);
    wr(63, 32'h3333_3333, 4'hF);
    read_one(1'b0, 0, SYS_ID, "ro_sysid", 1'b0, '0);
    read_one(1'b0, 1, TSTAMP, "ro_tstamp", 1'b0, '0);
    read_one(1'b0, 63, 32'h0, "unmapped63", 1'b0, '0);
    read_one(1'b0, 4, 32'hDEAD_12EF, "scratch_kept", 1'b0, '0);

    // Back-to-back user/ID reads
    baddr = '{6'd6, 6'd7, 6'd8, 6'd0, 6'd6, 6'd7, 6'd8, 6'd0};
    bexp  = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0, SYS_ID,
              32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0, SYS_ID};
    burst(8);
    check("burst_count", 64'(got.size()), 64'd8);
    check("burst_contig", 64'(last_i - first_i), 64'd7);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("burst_w%0d", i), 64'((i < got.size()) ? got[i] : 32'hXXXX_XXXX), 64'(bexp[i]));
    end

    // Coherent LO/HI across a 32-bit carry
    force dut2.uptime_q = 64'h0000_0001_FFFF_FFFF;
    address = 6'd2; read = 1'b1;
    tick();
    release dut2.uptime_q;
    address = 6'd3;
    tick();
    read = 1'b0;
    got.delete();
    if (rdv2) got.push_back(rdata2);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rdv2) got.push_back(rdata2);
    end
    check("coh_count", 64'(got.size()), 64'd2);
    check("coh_lo", 64'((got.size() > 0) ? got[0] : 32'hXXXX_XXXX), 64'hFFFF_FFFF);
    check("coh_hi", 64'((got.size() > 1) ? got[1] : 32'hXXXX_XXXX), 64'h0000_0001);
    tick(); tick();
    baddr[0] = 6'd2; baddr[1] = 6'd3;
    burst(2);
    check("coh2_count", 64'(got.size()), 64'd2);
    check("coh2_hi", 64'((got.size() > 1) ? got[1] : 32'hXXXX_XXXX), 64'h0000_0002);

    // Simultaneous read and write to scratch
    wr(4, 32'h1234_5678, 4'hF);
    read_one(1'b0, 4, 32'h1234_5678, "rw_same_old", 1'b1, 32'hFFFF_FFFF);
    read_one(1'b0, 4, 32'h1234_5678, "rw_same_after", 1'b0, '0);

    // Reset with three reads in flight on the latency-4 instance
    address = 6'd0; read = 1'b1;
    tick(); tick(); tick();
    read = 1'b0; reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    read_one(1'b1, 2, 32'h0, "rst_lo_restart", 1'b0, '0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdv4) npulse++;
    end
    check("rst_no_stale", 64'(npulse), 64'd0);
    read_one(1'b1, 4, 32'h0, "rst_scratch", 1'b0, '0);
    read_one(1'b1, 5, 32'h0204_0002, "info_rl4", 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
